// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default link constants and a
// frame-length helper, common to uart_tx and the future uart_rx.
package uart_pkg;

  localparam int unsigned DefClksPerBit = 868;  // 100 MHz / 115200
  localparam int unsigned DefDataBits   = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  // Clock cycles occupied by one complete frame on the line.
  function automatic int unsigned uart_frame_cycles(input int unsigned clks_per_bit,
                                                    input int unsigned data_bits,
                                                    input int unsigned stop_bits,
                                                    input bit          parity_en);
    return (1 + data_bits + (parity_en ? 1 : 0) + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit with tick_o. clear_i holds the count at zero.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntLast);

  // Next count: wrap on the last cycle of a bit, hold at zero while cleared.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, async frame out on tx_o
// (start, data LSB first, optional parity, stop bits). tx_o and done_o are flops.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
  parameter int unsigned DATA_BITS    = DefDataBits,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 ||
      STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx: illegal parameter value");
  end

  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 tick;
  logic                 handshake;

  assign tx_ready_o = (state_q == StIdle);
  assign busy_o     = ~tx_ready_o;
  assign handshake  = tx_valid_i & tx_ready_o;
  assign tx_o       = tx_q;
  assign done_o     = done_q;

  // Baud counter runs only while a frame is on the line.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear_i(tx_ready_o),
    .tick_o (tick)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;

  // Parity of the latched word, captured at handshake time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_d = handshake ? ((^tx_data_i) ^ PARITY_ODD[0]) : parity_q;
`endif

  // Frame sequencing: next state, shift register, bit counter and output bits.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (handshake) begin
          shreg_d   = tx_data_i;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (tick) begin
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d    = 1'b1;
            state_d = StStop;
`endif
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        // bit_cnt_q counts stop bits here.
        if (tick) begin
          if (bit_cnt_q == StopLast) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: dut_a (1 stop bit, even parity) and
// dut_b (2 stop bits, odd parity). Parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int Cpb = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       valid_a = 1'b0;
  logic       valid_b = 1'b0;
  logic       ready_a, tx_a, busy_a, done_a;
  logic       ready_b, tx_b, busy_b, done_b;
  int         sel = 0;
  logic       cur_tx, cur_ready, cur_busy, cur_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT(Cpb),
    .DATA_BITS   (8),
    .STOP_BITS   (1),
    .PARITY_ODD  (0)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .tx_data_i (tx_data),
    .tx_valid_i(valid_a),
    .tx_ready_o(ready_a),
    .tx_o      (tx_a),
    .busy_o    (busy_a),
    .done_o    (done_a)
  );

  uart_tx #(
    .CLKS_PER_BIT(Cpb),
    .DATA_BITS   (8),
    .STOP_BITS   (2),
    .PARITY_ODD  (1)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .tx_data_i (tx_data),
    .tx_valid_i(valid_b),
    .tx_ready_o(ready_b),
    .tx_o      (tx_b),
    .busy_o    (busy_b),
    .done_o    (done_b)
  );

  always_comb begin
    cur_tx    = (sel == 1) ? tx_b    : tx_a;
    cur_ready = (sel == 1) ? ready_b : ready_a;
    cur_busy  = (sel == 1) ? busy_b  : busy_a;
    cur_done  = (sel == 1) ? done_b  : done_a;
  end

  // bits[i] is the i-th bit on the line (start, d0..d7, stop); par = even parity.
  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
    logic       par;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_valid(input int s, input logic v);
    if (s == 1) valid_b = v;
    else valid_a = v;
  endtask

  // Present a word and return just after the handshake edge.
  task automatic launch(input int s, input logic [7:0] d);
    bit ok;
    ok  = 1'b0;
    sel = s;
    @(negedge clk);
    tx_data = d;
    set_valid(s, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (cur_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("launch ready timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  // Check every cycle of a frame whose handshake edge has just passed.
  task automatic run_frame(input int s, input vec_t v, input int stops, input logic par_odd,
                           input bit hold, input logic [7:0] next_data, input bit poke,
                           input string tag);
    int   nbits;
    int   idx;
    logic e;
    nbits = 9 + P + stops;
    for (int k = 1; k <= nbits * Cpb; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) set_valid(s, 1'b0);
      idx = (k - 1) / Cpb;
      if (idx < 9) e = v.bits[idx];
      else if (P == 1 && idx == 9) e = v.par ^ par_odd;
      else e = 1'b1;
      check($sformatf("%s tx k=%0d", tag, k), {31'd0, cur_tx}, {31'd0, e});
      if (k == 1) begin
        check($sformatf("%s busy at start", tag), {31'd0, cur_busy}, 32'd1);
        check($sformatf("%s ready at start", tag), {31'd0, cur_ready}, 32'd0);
        check($sformatf("%s done at start", tag), {31'd0, cur_done}, 32'd0);
      end
      if (k == nbits * Cpb) begin
        check($sformatf("%s done early", tag), {31'd0, cur_done}, 32'd0);
      end
      if (poke && k == 10) begin
        tx_data = 8'h3C;
        set_valid(s, 1'b1);
      end
      if (poke && k == 11) begin
        check($sformatf("%s ready while busy", tag), {31'd0, cur_ready}, 32'd0);
        set_valid(s, 1'b0);
      end
    end
    @(negedge clk);
    check($sformatf("%s done pulse", tag), {31'd0, cur_done}, 32'd1);
    check($sformatf("%s ready at done", tag), {31'd0, cur_ready}, 32'd1);
    check($sformatf("%s busy at done", tag), {31'd0, cur_busy}, 32'd0);
    check($sformatf("%s tx idle at done", tag), {31'd0, cur_tx}, 32'd1);
    if (hold) begin
      tx_data = next_data;
    end else begin
      @(negedge clk);
      check($sformatf("%s done low after", tag), {31'd0, cur_done}, 32'd0);
    end
  endtask

  initial begin
    int seen_done;
    int seen_low;
    vecs[0] = '{8'hA5, 10'b1_1010_0101_0, 1'b0};
    vecs[1] = '{8'h00, 10'b1_0000_0000_0, 1'b0};
    vecs[2] = '{8'hFF, 10'b1_1111_1111_0, 1'b0};
    vecs[3] = '{8'h3C, 10'b1_0011_1100_0, 1'b0};
    vecs[4] = '{8'h07, 10'b1_0000_0111_0, 1'b1};
    vecs[5] = '{8'h81, 10'b1_1000_0001_0, 1'b0};
    vecs[6] = '{8'h5A, 10'b1_0101_1010_0, 1'b0};

    // Reset values while reset is held.
    #2 rst = 1'b1;
    #2;
    check("reset tx_a", {31'd0, tx_a}, 32'd1);
    check("reset ready_a", {31'd0, ready_a}, 32'd1);
    check("reset busy_a", {31'd0, busy_a}, 32'd0);
    check("reset done_a", {31'd0, done_a}, 32'd0);
    check("reset tx_b", {31'd0, tx_b}, 32'd1);
    check("reset ready_b", {31'd0, ready_b}, 32'd1);
    check("reset busy_b", {31'd0, busy_b}, 32'd0);
    check("reset done_b", {31'd0, done_b}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single frames from the table; first one also pokes tx_valid mid-frame.
    for (int i = 0; i < 6; i++) begin
      launch(0, vecs[i].data);
      run_frame(0, vecs[i], 1, 1'b0, 1'b0, 8'h00, (i == 0),
                $sformatf("vec%0d", i));
    end

    // Back-to-back with tx_valid held: 0x00 then 0xFF.
    launch(0, 8'h00);
    run_frame(0, vecs[1], 1, 1'b0, 1'b1, 8'hFF, 1'b0, "b2b first");
    run_frame(0, vecs[2], 1, 1'b0, 1'b0, 8'h00, 1'b0, "b2b second");

    // Reset during data bit 3 of 0x5A.
    launch(0, 8'h5A);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) valid_a = 1'b0;
      check($sformatf("abort tx k=%0d", k), {31'd0, tx_a},
            {31'd0, vecs[6].bits[(k - 1) / Cpb]});
    end
    rst = 1'b1;
    #1;
    check("abort tx", {31'd0, tx_a}, 32'd1);
    check("abort ready", {31'd0, ready_a}, 32'd1);
    check("abort busy", {31'd0, busy_a}, 32'd0);
    check("abort done", {31'd0, done_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    seen_low  = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done_a) seen_done++;
      if (!tx_a) seen_low++;
    end
    check("abort no done pulse", seen_done, 32'd0);
    check("abort line idle", seen_low, 32'd0);
    launch(0, 8'h81);
    run_frame(0, vecs[5], 1, 1'b0, 1'b0, 8'h00, 1'b0, "after abort");

    // Two stop bits, odd parity instance.
    launch(1, 8'hFF);
    run_frame(1, vecs[2], 2, 1'b1, 1'b0, 8'h00, 1'b0, "stop2");
    launch(1, 8'h07);
    run_frame(1, vecs[4], 2, 1'b1, 1'b0, 8'h00, 1'b0, "stop2 odd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
